lane_register: RTL and testbench
================================

// Module: lane_register
// PURPOSE
//   N-bit load/store register split into LANES independently loadable lanes.
//   Generalises the two-half (high/low) load register to any lane count.
//   Adds lane rotation, synchronous clear, and a serial lane-fill sequencer.
//   The sequencer loads one lane per handshake, MSB lane first.
//   Used as a datapath holding register fed either by a wide bus or by a narrow stream.
// PARAMETERS
//   LANES  4  number of lanes (>=2)
//   LW     8  lane width in bits (>=1)
//   N      LANES*LW  total width (derived; do not override)
// PORTS
//   clk        in   1      rising-edge clock
//   clear_n    in   1      async active-low reset
//   sync_clr   in   1      synchronous clear of out; aborts serial fill
//   lane_load  in   LANES  per-lane parallel load enable; bit k selects lane k
//   lane_in    in   N      parallel data; lane k = bits [k*LW+LW-1 : k*LW]
//   rot        in   1      rotate out left by one lane
//   ser_start  in   1      start serial fill (honoured only in IDLE)
//   ser_valid  in   1      ser_in carries a valid lane word
//   ser_in     in   LW     serial lane data
//   ser_ready  out  1      sequencer accepts ser_in this cycle
//   ser_done   out  1      one-cycle pulse after the last lane is written
//   busy       out  1      sequencer not IDLE
//   out        out  N      register contents
// BEHAVIOUR
//   - Reset (clear_n=0, async): out=0, state=IDLE, lane index=0.
//     ser_ready=0, ser_done=0, busy=0. Takes effect immediately, mid-fill included.
//   - All outputs are registered or decoded from state; no combinational path from inputs.
//   - Register updates are visible on out one cycle after the enabling edge.
//   - Per-edge priority: sync_clr > serial write > lane_load > rot > hold.
//   - sync_clr=1:
//     - out<=0 and state<=IDLE, with no ser_done pulse.
//     - All other inputs are ignored that cycle, including ser_start.
//   - lane_load (IDLE or DONE only):
//     - Each lane with its enable bit set takes lane_in; every other lane holds.
//     - lane_load=0 with rot=0 holds the register.
//   - rot (IDLE or DONE, lane_load==0):
//     - out <= {out[N-LW-1:0], out[N-1:N-LW]}.
//     - The top lane wraps to lane 0.
//     - If any lane_load bit is set, rot is ignored for that cycle.
//   - Sequencer FSM:
//     - IDLE:
//       - ser_start=1 -> FILL, lane index <= LANES-1.
//       - lane_load/rot in that same cycle are still applied.
//     - FILL:
//       - ser_ready=1, busy=1.
//       - On ser_valid&&ser_ready, lane[index] <= ser_in.
//       - If index==0 -> DONE; otherwise index decrements.
//       - ser_valid=0 stalls indefinitely with no change.
//       - lane_load, rot and ser_start are ignored.
//     - DONE:
//       - ser_done=1, busy=1, ser_ready=0. Lasts exactly one cycle, then -> IDLE.
//       - lane_load/rot are honoured; ser_start is ignored.
//   - Lanes not yet written during a fill keep their prior values.
//   - Index width is $clog2(LANES). No wrap occurs because the FSM exits at index 0.
// TESTING  (LANES=4, LW=8)
//   1. Reset: pulse clear_n low mid-cycle while out=32'hDEADBEEF.
//      -> out=0 immediately, busy=0, ser_ready=0.
//   2. Parallel load from out=0: lane_load=4'b0101, lane_in=32'hAABBCCDD -> out=32'h00BB00DD.
//      Next cycle, lane_load=4'b1010 with the same lane_in -> out=32'hAABBCCDD.
//   3. Rotate: out=32'h11223344, rot=1 for 1 cycle -> out=32'h22334411.
//      Then rot=1 together with lane_load=4'b0001, lane_in=32'h000000FF -> out=32'h223344FF (no rotate).
//   4. Serial fill: ser_start, then words 8'h01, 8'h02, 8'h03, 8'h04, with ser_valid low for 2 cycles between 02 and 03.
//      -> out=32'h01020304.
//      -> ser_done high exactly 1 cycle, one cycle after the 04 handshake; busy low the cycle after that.
//   5. Fill abort: out=32'hFFFFFFFF, ser_start, write 8'hA5, then sync_clr.
//      -> out=0, state IDLE, no ser_done pulse, ser_ready=0.
//   6. Lockout: during FILL, assert lane_load=4'hF and rot -> out changes only via serial writes.
//      A ser_start in FILL or DONE does not restart the sequence.

Source files
------------

// File: rtl/lane_register.sv
// lane_register: LANES-lane load/store register with rotation, sync clear and
// an MSB-lane-first serial fill sequencer.
module lane_register #(
    parameter int LANES = 4,
    parameter int LW    = 8,
    localparam int N    = LANES * LW
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             sync_clr,
    input  logic [LANES-1:0] lane_load,
    input  logic [N-1:0]     lane_in,
    input  logic             rot,
    input  logic             ser_start,
    input  logic             ser_valid,
    input  logic [LW-1:0]    ser_in,
    output logic             ser_ready,
    output logic             ser_done,
    output logic             busy,
    output logic [N-1:0]     out
);
    localparam int IW = $clog2(LANES);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] FILL = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [N-1:0]  out_q, out_d;
    logic [1:0]    state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;

    always_comb begin
        out_d   = out_q;
        state_d = state_q;
        idx_d   = idx_q;
        if (sync_clr) begin
            out_d   = '0;
            state_d = IDLE;
        end else if (state_q == FILL) begin
            if (ser_valid) begin
                out_d[int'(idx_q)*LW +: LW] = ser_in;
                state_d = (idx_q == '0) ? DONE : FILL;
                idx_d   = (idx_q == '0) ? idx_q : idx_q - 1'b1;
            end
        end else begin
            if (|lane_load) begin
                for (int k = 0; k < LANES; k++)
                    if (lane_load[k]) out_d[k*LW +: LW] = lane_in[k*LW +: LW];
            end else if (rot) begin
                out_d = {out_q[N-LW-1:0], out_q[N-1:N-LW]};
            end
            // DONE always returns to IDLE; a start is only honoured from IDLE
            state_d = (state_q == IDLE && ser_start) ? FILL : IDLE;
            idx_d   = (state_q == IDLE && ser_start) ? IW'(LANES - 1) : idx_q;
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            out_q   <= '0;
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            out_q   <= out_d;
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    assign out       = out_q;
    assign ser_ready = (state_q == FILL);
    assign ser_done  = (state_q == DONE);
    assign busy      = (state_q != IDLE);
endmodule

// File: tb/tb_lane_register.sv
// tb_lane_register: vector table, directed multi-cycle sequences and random
// stimulus checked against a lane-array reference model.
module tb_lane_register;
    logic        clk = 0;
    logic        clear_n = 0;
    logic        sync_clr = 0;
    logic [3:0]  lane_load = 0;
    logic [31:0] lane_in = 0;
    logic        rot = 0;
    logic        ser_start = 0;
    logic        ser_valid = 0;
    logic [7:0]  ser_in = 0;
    logic        ser_ready, ser_done, busy;
    logic [31:0] dout;

    int total = 0;
    int bad = 0;

    lane_register #(.LANES(4), .LW(8)) dut (
        .clk(clk), .clear_n(clear_n), .sync_clr(sync_clr), .lane_load(lane_load),
        .lane_in(lane_in), .rot(rot), .ser_start(ser_start), .ser_valid(ser_valid),
        .ser_in(ser_in), .ser_ready(ser_ready), .ser_done(ser_done), .busy(busy),
        .out(dout)
    );

    always #5 clk = ~clk;

    // reference model: lanes as an array, mode 0=idle 1=fill 2=done, next lane to fill
    logic [7:0] m_l [4];
    int m_mode;
    int m_next;

    function automatic logic [31:0] m_out();
        return {m_l[3], m_l[2], m_l[1], m_l[0]};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 4; k++) m_l[k] = 0;
        m_mode = 0;
        m_next = 0;
    endtask

    task automatic model_step();
        logic [7:0] top;
        if (sync_clr) begin
            for (int k = 0; k < 4; k++) m_l[k] = 0;
            m_mode = 0;
        end else if (m_mode == 1) begin
            if (ser_valid) begin
                m_l[m_next] = ser_in;
                if (m_next == 0) m_mode = 2;
                else m_next = m_next - 1;
            end
        end else begin
            if (lane_load != 0) begin
                for (int k = 0; k < 4; k++)
                    if (lane_load[k]) m_l[k] = lane_in[k*8 +: 8];
            end else if (rot) begin
                top = m_l[3];
                for (int k = 3; k > 0; k--) m_l[k] = m_l[k-1];
                m_l[0] = top;
            end
            if (m_mode == 0 && ser_start) begin
                m_mode = 1;
                m_next = 3;
            end else begin
                m_mode = 0;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk_model(input string name);
        chk({name, ".out"}, dout, m_out());
        chk({name, ".busy"}, {31'd0, busy}, {31'd0, m_mode != 0});
        chk({name, ".ready"}, {31'd0, ser_ready}, {31'd0, m_mode == 1});
        chk({name, ".done"}, {31'd0, ser_done}, {31'd0, m_mode == 2});
    endtask

    task automatic idle_inputs();
        sync_clr = 0; lane_load = 0; lane_in = 0; rot = 0;
        ser_start = 0; ser_valid = 0; ser_in = 0;
    endtask

    task automatic step(input string name);
        model_step();
        @(posedge clk);
        #1;
        chk_model(name);
    endtask

    typedef struct {
        logic        clr;
        logic [3:0]  ld;
        logic [31:0] din;
        logic        r;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [9];

    initial begin
        vecs[0] = '{0, 4'b0101, 32'hAABBCCDD, 0, 32'h00BB00DD};
        vecs[1] = '{0, 4'b1010, 32'hAABBCCDD, 0, 32'hAABBCCDD};
        vecs[2] = '{0, 4'b1111, 32'h11223344, 0, 32'h11223344};
        vecs[3] = '{0, 4'b0000, 32'h0,        1, 32'h22334411};
        vecs[4] = '{0, 4'b0001, 32'h000000FF, 1, 32'h223344FF};
        vecs[5] = '{0, 4'b0000, 32'h12345678, 0, 32'h223344FF};
        vecs[6] = '{1, 4'b1111, 32'h12345678, 1, 32'h00000000};
        vecs[7] = '{0, 4'b1000, 32'h80123456, 0, 32'h80000000};
        vecs[8] = '{0, 4'b0000, 32'h0,        1, 32'h00000080};

        model_reset();
        repeat (2) @(posedge clk);
        #1 clear_n = 1;
        chk("reset.out", dout, 32'h0);
        chk("reset.busy", {31'd0, busy}, 32'd0);

        // reset mid-cycle while holding DEADBEEF
        lane_load = 4'hF; lane_in = 32'hDEADBEEF;
        step("pre_rst");
        idle_inputs();
        chk("pre_rst.val", dout, 32'hDEADBEEF);
        #3 clear_n = 0;
        #1;
        model_reset();
        chk("async_rst.out", dout, 32'h0);
        chk("async_rst.busy", {31'd0, busy}, 32'd0);
        chk("async_rst.ready", {31'd0, ser_ready}, 32'd0);
        @(posedge clk);
        #1 clear_n = 1;

        for (int i = 0; i < 9; i++) begin
            sync_clr = vecs[i].clr; lane_load = vecs[i].ld;
            lane_in = vecs[i].din; rot = vecs[i].r;
            step("vec");
            chk($sformatf("vec%0d", i), dout, vecs[i].exp);
            idle_inputs();
        end

        // serial fill with a 2-cycle stall and lockout attempts during FILL
        ser_start = 1;
        step("fill_start");
        chk("fill_start.ready", {31'd0, ser_ready}, 32'd1);
        ser_start = 1; lane_load = 4'hF; lane_in = 32'h55555555; rot = 1;
        ser_valid = 1; ser_in = 8'h01; step("fill_w1");
        ser_in = 8'h02; step("fill_w2");
        ser_valid = 0; step("fill_stall1"); step("fill_stall2");
        chk("fill_lock", dout, 32'h01020080);
        ser_valid = 1; ser_in = 8'h03; step("fill_w3");
        ser_in = 8'h04; lane_load = 0; rot = 0; step("fill_w4");
        chk("fill.out", dout, 32'h01020304);
        chk("fill.done", {31'd0, ser_done}, 32'd1);
        ser_valid = 0; ser_start = 1;
        step("fill_after");
        chk("fill_after.done", {31'd0, ser_done}, 32'd0);
        chk("fill_after.busy", {31'd0, busy}, 32'd0);
        idle_inputs();
        step("fill_idle");

        // abort
        lane_load = 4'hF; lane_in = 32'hFFFFFFFF; step("abort_ld");
        idle_inputs(); ser_start = 1; step("abort_start");
        ser_start = 0; ser_valid = 1; ser_in = 8'hA5; step("abort_w");
        chk("abort_w.out", dout, 32'hA5FFFFFF);
        sync_clr = 1; ser_start = 1; step("abort_clr");
        chk("abort.out", dout, 32'h0);
        chk("abort.ready", {31'd0, ser_ready}, 32'd0);
        chk("abort.done", {31'd0, ser_done}, 32'd0);
        idle_inputs(); step("abort_after");
        chk("abort_after.done", {31'd0, ser_done}, 32'd0);

        // async reset in the middle of a fill
        ser_start = 1; step("rfill_start");
        ser_start = 0; ser_valid = 1; ser_in = 8'h77; step("rfill_w");
        idle_inputs();
        #3 clear_n = 0;
        #1;
        model_reset();
        chk("rfill.busy", {31'd0, busy}, 32'd0);
        chk("rfill.ready", {31'd0, ser_ready}, 32'd0);
        chk("rfill.out", dout, 32'h0);
        @(posedge clk);
        #1 clear_n = 1;

        for (int i = 0; i < 400; i++) begin
            sync_clr  = ($urandom_range(0, 19) == 0);
            lane_load = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
            lane_in   = $urandom;
            rot       = $urandom_range(0, 1);
            ser_start = ($urandom_range(0, 3) == 0);
            ser_valid = $urandom_range(0, 1);
            ser_in    = 8'($urandom);
            step("rand");
        end
        idle_inputs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
